reg_write_arbiter: RTL

REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

---
 rtl/reg_write_arbiter_pkg.sv | 17 +
 rtl/reg_write_arbiter_if.sv | 16 +
 rtl/reg_write_arbiter_rr_pick.sv | 26 ++
 rtl/reg_write_arbiter.sv | 118 +++++++++++
 4 files changed

// File: rtl/reg_write_arbiter_pkg.sv
// Shared definitions for the register write arbiter: FSM state encoding,
// write-counter width and the saturating increment used by the counter.
package reg_write_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        WRITE = 2'd2
    } state_e;

    localparam int CNT_W = 16;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/reg_write_arbiter_if.sv
// Requester-side bus of the register write arbiter: level requests with
// per-requester data in, one-hot grant/ack and the shared register out.
interface reg_write_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int DW    = 8
);
    logic [N_REQ-1:0]    req;
    logic [N_REQ*DW-1:0] wdata;
    logic [N_REQ-1:0]    gnt;
    logic [N_REQ-1:0]    ack;
    logic [DW-1:0]       q;
    logic                busy;

    modport master (output req, wdata, input gnt, ack, q, busy);
    modport slave  (input req, wdata, output gnt, ack, q, busy);
endinterface

// File: rtl/reg_write_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the one-hot index of the first
// active request found scanning upward (with wrap) from ptr.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int PW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [N_REQ-1:0] win
);
    logic [PW-1:0] idx;
    logic          found;

    always_comb begin
        win   = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = PW'((int'(ptr) + k) % N_REQ);
            if (!found && req[idx]) begin
                win[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end
endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter granting N_REQ requesters write access to one shared
// register. Define REG_WRITE_ARBITER_COUNT_EN to add the wr_count output.
module reg_write_arbiter
    import reg_write_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int DW    = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    reg_write_arbiter_if.slave     bus
`ifdef REG_WRITE_ARBITER_COUNT_EN
    ,
    output logic [CNT_W-1:0]       wr_count
`endif
);
    localparam int PW = $clog2(N_REQ);

    state_e           state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [N_REQ-1:0] ack_q, ack_d;
    logic [DW-1:0]    q_q, q_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [N_REQ-1:0] pick;
    logic [PW-1:0]    win_idx;
    logic [DW-1:0]    sel_data;
    logic             win_held;

    rr_pick #(.N_REQ(N_REQ), .PW(PW)) u_rr_pick (
        .req (bus.req),
        .ptr (ptr_q),
        .win (pick)
    );

    // The registered grant remembers the winner through the GRANT cycle.
    always_comb begin
        win_idx  = '0;
        sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_q[i]) begin
                win_idx  = PW'(i);
                sel_data = bus.wdata[i*DW +: DW];
            end
        end
    end

    assign win_held = |(bus.req & gnt_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|bus.req) state_d = GRANT;
            GRANT:   state_d = win_held ? WRITE : IDLE;
            WRITE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        gnt_d = '0;
        ack_d = '0;
        q_d   = q_q;
        ptr_d = ptr_q;
        case (state_q)
            IDLE: gnt_d = pick;
            GRANT: begin
                if (win_held) begin
                    q_d   = sel_data;
                    ack_d = gnt_q;
                    ptr_d = (int'(win_idx) == N_REQ - 1) ? '0 : win_idx + PW'(1);
                end
            end
            default: ;
        endcase
    end

    // Reset clears the register contents too, so a write caught in GRANT is lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_q <= '0;
            ack_q <= '0;
            q_q   <= '0;
            ptr_q <= '0;
        end else begin
            gnt_q <= gnt_d;
            ack_q <= ack_d;
            q_q   <= q_d;
            ptr_q <= ptr_d;
        end
    end

    assign bus.gnt  = gnt_q;
    assign bus.ack  = ack_q;
    assign bus.q    = q_q;
    assign bus.busy = (state_q != IDLE);

`ifdef REG_WRITE_ARBITER_COUNT_EN
    logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;

    always_comb begin
        wr_cnt_d = wr_cnt_q;
        if (|ack_d) wr_cnt_d = sat_inc(wr_cnt_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) wr_cnt_q <= '0;
        else     wr_cnt_q <= wr_cnt_d;
    end

    assign wr_count = wr_cnt_q;
`endif

endmodule
